// File: rtl/mac_seq_pkg.sv
// rtl/mac_seq_pkg.sv - shared state encoding and defaults for the MAC array job sequencer
package mac_seq_pkg;

  localparam int DEF_N_MACS = 4;
  localparam int DEF_ACC_W  = 16;
  localparam int DEF_LEN_W  = 8;

  localparam int SEQ_TIMEOUT_CYCLES = 255;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/skew_line.sv
// rtl/skew_line.sv - per-column valid shift register that tracks the a_in wavefront
module skew_line
  import mac_seq_pkg::*;
#(
  parameter int N_MACS = DEF_N_MACS
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              shift_in,
  output logic [N_MACS-1:0] bits
);

  // Bit i marks the sample currently sitting at column i of the array.
  always_ff @(posedge clk) begin
    if (clear) begin
      bits <= '0;
    end else begin
      bits <= (bits << 1) | N_MACS'(shift_in);
    end
  end

endmodule

// File: rtl/mac_array_sequencer.sv
// rtl/mac_array_sequencer.sv - clears, feeds and drains one dot-product job through mac_array
// Optional FEED idle timeout with sticky err is enabled by SEQ_TIMEOUT_EN.
module mac_array_sequencer
  import mac_seq_pkg::*;
#(
  parameter int N_MACS = DEF_N_MACS,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              a_valid,
  input  logic [ACC_W-1:0]  a_data,
  output logic              a_ready,
  output logic [ACC_W-1:0]  arr_a_in,
  output logic [N_MACS-1:0] arr_valid,
  output logic [N_MACS-1:0] arr_clear,
  input  logic [N_MACS-1:0] arr_valid_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  seq_state_t        state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic [N_MACS-1:0] skew;
  logic              hs;
  logic              timeout;
  logic              unused_valid_out;

  // a_ready is only ever set in FEED, so it alone qualifies the handshake.
  assign hs               = a_valid & a_ready;
  assign arr_valid        = skew;
  assign unused_valid_out = ^arr_valid_out;

  skew_line #(.N_MACS(N_MACS)) u_skew (
    .clk      (clk),
    .clear    (rst),
    .shift_in (hs),
    .bits     (skew)
  );

`ifdef SEQ_TIMEOUT_EN
  logic [7:0] idle_cnt;

  assign timeout = (state == S_FEED) && !hs && (idle_cnt == 8'(SEQ_TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst || state != S_FEED || hs) begin
      idle_cnt <= '0;
    end else if (idle_cnt != 8'(SEQ_TIMEOUT_CYCLES)) begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state == S_IDLE && start) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      len_q     <= '0;
      cnt       <= '0;
      arr_a_in  <= '0;
      arr_clear <= '0;
      a_ready   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      arr_clear <= '0;
      done      <= 1'b0;
      if (hs) begin
        arr_a_in <= a_data;
      end
      unique case (state)
        S_IDLE: begin
          if (start) begin
            len_q     <= len;
            cnt       <= '0;
            arr_clear <= '1;
            busy      <= 1'b1;
            state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (len_q == '0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            a_ready <= 1'b1;
            state   <= S_FEED;
          end
        end
        S_FEED: begin
          if (hs) begin
            cnt <= cnt + LEN_W'(1);
          end
          // Comparing against len-1 keeps cnt from ever wrapping at len = 2^LEN_W-1.
          if ((hs && cnt == len_q - LEN_W'(1)) || timeout) begin
            a_ready <= 1'b0;
            state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (skew == '0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mac_array_sequencer.md
# mac_array_sequencer

Job-level controller that sequences one complete dot-product job through `mac_array`. It clears the accumulators, then accepts a stream of `len` input samples over a valid/ready handshake. Each accepted sample produces a skewed per-MAC `valid_in_0` wavefront matching the array's one-hop-per-cycle `a_in` forwarding. After draining, it signals completion. It replaces the fixed-pattern `loading_fsm` and sits between the upstream sample source and `mac_array`.

## Interface
- `N_MACS`, 4, number of MAC columns driven
- `ACC_W`, 16, sample/accumulator width
- `LEN_W`, 8, width of the job length field
- `clk` in 1: sole clock, rising edge
- `rst` in 1: reset, synchronous and active-high
- `start` in 1: job request, sampled only in IDLE
- `len` in LEN_W: sample count K for the job, latched with `start`
- `a_valid` in 1: upstream sample valid
- `a_data` in ACC_W: upstream sample, signed
- `a_ready` out 1: sequencer accepts a sample this cycle
- `arr_a_in` out ACC_W: registered sample to `mac_array.a_in`
- `arr_valid` out N_MACS: skewed strobes to `mac_array.valid_in_0`
- `arr_clear` out N_MACS: accumulator clear to `mac_array.clear`
- `arr_valid_out` in N_MACS: `mac_array.valid_out`, monitored only
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle completion pulse
- `err` out 1: sticky timeout flag; tied 0 when `SEQ_TIMEOUT_EN` is absent

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- **IDLE**
  - If `start` is high: latch `len`, go to CLEAR, and clear `err`.
  - Otherwise: `a_valid` is ignored.
- **CLEAR**
  - `arr_clear` is all-ones for exactly one cycle.
  - Next state is FEED, or DONE if the latched len is 0.
- **FEED**
  - `a_ready` is 1.
  - A handshake (`a_valid & a_ready`) registers `a_data` into `arr_a_in`, shifts 1 into skew bit 0, and increments the sample count.
  - With no handshake, a 0 is shifted in (bubble) and `arr_a_in` holds its value.
  - `arr_valid[i]` equals skew bit i; skew bit i+1 takes bit i each cycle.
  - When the count reaches len on a handshake, go to DRAIN. `a_ready` drops in the same cycle as the transition.
- **DRAIN**
  - `a_ready` is 0 and the skew line keeps shifting 0s.
  - When all skew bits are 0, go to DONE.
- **DONE**
  - `done` is 1 for one cycle, then go to IDLE.
- **Boundary conditions**
  - `start` while `busy`: ignored, with no latch and no effect on the current job.
  - `len` = 0: runs CLEAR → DONE; no samples are consumed and `arr_valid` stays 0.
  - `len` = 2^LEN_W−1 is supported; the count register is LEN_W bits and never wraps inside a job.
  - `rst` mid-job: the next state is IDLE, the skew line clears, every output takes its reset value, and no `done` is emitted.

## Timing
- Reset values: `a_ready`, `busy`, `done`, `err` = 0; `arr_valid`, `arr_clear` = 0; `arr_a_in` = 0.
- `start` sampled at edge t: `arr_clear` is high in cycle t+1, and `a_ready` is high from cycle t+2.
- Handshake at edge e: `arr_a_in` = sample and `arr_valid[0]` = 1 in cycle e+1. `arr_valid[i]` = 1 in cycle e+1+i.
- Last handshake at edge e_L: `done` is high in cycle e_L+N_MACS+2, and `busy` falls in the cycle after that.
- Zero-bubble throughput is one sample per cycle. Bubbles preserve the skew exactly.
- `arr_valid_out` has no effect on the FSM. Results are valid in the array once `done` is seen.

## Configuration
- Macro: `SEQ_TIMEOUT_EN`.
- **Defined:**
  - In FEED, an 8-bit idle counter increments on every cycle without a handshake and resets on each handshake.
  - When the counter reaches 255: set `err`, go to DRAIN, then DONE, which emits `done` normally.
  - `err` stays set until the next accepted `start` or `rst`.
- **Undefined:** FEED waits indefinitely; `err` is constant 0 and no counter is synthesized.

## Structure
- Package `mac_seq_pkg` holds:
  - `seq_state_t`, the state enum.
  - The default `N_MACS`/`ACC_W`/`LEN_W` values.
  - `SEQ_TIMEOUT_CYCLES` = 255.
- One sub-module, `skew_line`: an N_MACS-bit valid shift register with synchronous clear, instantiated once.

## Test plan
- Weights 2,3,4,5; len=1; a=10 → `arr_valid` walks bits 0..3 over 4 consecutive cycles; `done` is high 6 cycles after the handshake; acc = 20,30,40,50.
- len=3; samples 1,2,3 with one-cycle `a_valid` gaps → skew preserved with bubbles; acc = 6×w (12,18,24,30); exactly one `done`.
- `start` pulsed during FEED with len=5 → ignored; the job completes after its original 3 samples.
- len=0 → `arr_clear` pulse, then `done` two cycles after `start`; `a_ready` never high.
- `rst` asserted in FEED after 1 of 4 samples → the next cycle has all outputs 0 and state IDLE; a fresh job with len=1, a=7 yields acc = 14,21,28,35.
- With `SEQ_TIMEOUT_EN` defined, len=2, one sample then `a_valid` held at 0 → `err` = 1 and `done` pulses after the 255-cycle idle count plus drain. Without the macro, `busy` stays high and `err` stays 0.
